// File: rtl/pc_gen_pkg.sv
// Shared next-PC encodings and default vectors for the fetch-path PC generator.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_RIG    = 3'b011,
        NPC_ERET   = 3'b100
    } npc_op_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

    // Ops that redirect through the delay slot when delay-slot mode is on.
    function automatic logic is_redirect(input logic [2:0] op);
        return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_RIG);
    endfunction

    function automatic logic is_control(input logic [2:0] op);
        return is_redirect(op) || (op == NPC_ERET);
    endfunction

endpackage

// File: rtl/pc_gen_npc_target.sv
// Combinational redirect-target calculation for the instruction at pc.
module pc_gen_npc_target
    import pc_gen_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] pc,
    input  logic [25:0] imm,
    input  logic [31:0] rsv,
    input  logic [31:0] epc_in,
    output logic [31:0] target
);

    logic        [31:0] seq_pc;
    logic signed [31:0] br_off;

    assign seq_pc = pc + 32'd4;
    assign br_off = {{14{imm[15]}}, imm[15:0], 2'b00};

    always_comb begin
        target = seq_pc;
        case (op)
            NPC_BRANCH: target = seq_pc + br_off;
            NPC_JUMP:   target = {seq_pc[31:28], imm, 2'b00};
            NPC_RIG:    target = rsv;
            NPC_ERET:   target = epc_in;
            default:    target = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Architectural PC register with stall hold, exception redirect and optional delay slot.
// Build option NPC_ALIGN_CHECK_EN: misaligned JR/ERET targets raise align_err and take the exception vector.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          DELAY_SLOT = 0,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic [25:0] imm,
    input  logic [31:0] rsv,
    input  logic [31:0] epc_in,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic [31:0] exc_epc,
    output logic        exc_bd,
    output logic        ds_err,
    output logic        align_err
);

    localparam logic DS_EN = (DELAY_SLOT != 0);

    logic [31:0] target;
    logic [31:0] pending_target;
    logic        pending_valid;
    logic        slot_busy;
    logic        defer;
    logic        take_exc;

    pc_gen_npc_target u_npc_target (
        .op     (npc_op),
        .pc     (pc),
        .imm    (imm),
        .rsv    (rsv),
        .epc_in (epc_in),
        .target (target)
    );

    assign pc_plus4  = pc + 32'd4;
    assign slot_busy = DS_EN && pending_valid;
    assign defer     = DS_EN && !pending_valid && is_redirect(npc_op);

`ifdef NPC_ALIGN_CHECK_EN
    // A discarded op in the delay slot never faults; only a live JR/ERET does.
    assign align_err = !slot_busy
                     && ((npc_op == NPC_RIG) || (npc_op == NPC_ERET))
                     && (target[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    assign take_exc = exc_req || align_err;

    always_comb begin
        npc = target;
        if (rst) begin
            npc = RESET_PC;
        end else if (take_exc) begin
            npc = EXC_VECTOR;
        end else if (slot_busy) begin
            npc = pending_target;
        end else if (defer) begin
            npc = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else if (take_exc) begin
            pc            <= EXC_VECTOR;
            pending_valid <= 1'b0;
        end else if (!stall) begin
            pc <= npc;
            if (slot_busy) begin
                pending_valid <= 1'b0;
            end else if (defer) begin
                pending_valid  <= 1'b1;
                pending_target <= target;
            end
        end
    end

    // While a redirect is pending, pc is the delay-slot instruction; its branch sits at pc-4.
    assign exc_epc = pending_valid ? (pc - 32'd4) : pc;
    assign exc_bd  = pending_valid;
    assign ds_err  = slot_busy && is_control(npc_op);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: one instance without and one with the delay slot, checked against a queue-based model.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        exc;
        logic [2:0]  op;
        logic [25:0] imm;
        logic [31:0] rsv;
        logic [31:0] epc;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] npc;
        logic [31:0] exc_epc;
        logic        exc_bd;
        logic        ds_err;
        logic        align_err;
    } out_t;

    typedef struct {
        in_t         v;
        logic [31:0] exp_pc;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in0, in1;
    logic [31:0] pc_0, pp4_0, npc_0, epc_0, pc_1, pp4_1, npc_1, epc_1;
    logic        bd_0, dse_0, ae_0, bd_1, dse_1, ae_1;
    out_t        o [2];

    always_comb begin
        o[0] = {pc_0, pp4_0, npc_0, epc_0, bd_0, dse_0, ae_0};
        o[1] = {pc_1, pp4_1, npc_1, epc_1, bd_1, dse_1, ae_1};
    end

    pc_gen #(.DELAY_SLOT(0)) dut0 (
        .clk(clk), .rst(in0.rst), .stall(in0.stall), .npc_op(in0.op), .imm(in0.imm),
        .rsv(in0.rsv), .epc_in(in0.epc), .exc_req(in0.exc),
        .pc(pc_0), .pc_plus4(pp4_0), .npc(npc_0), .exc_epc(epc_0),
        .exc_bd(bd_0), .ds_err(dse_0), .align_err(ae_0)
    );

    pc_gen #(.DELAY_SLOT(1)) dut1 (
        .clk(clk), .rst(in1.rst), .stall(in1.stall), .npc_op(in1.op), .imm(in1.imm),
        .rsv(in1.rsv), .epc_in(in1.epc), .exc_req(in1.exc),
        .pc(pc_1), .pc_plus4(pp4_1), .npc(npc_1), .exc_epc(epc_1),
        .exc_bd(bd_1), .ds_err(dse_1), .align_err(ae_1)
    );

    // Reference state: the PC and a queue holding a deferred redirect target.
    logic [31:0] m_pc [2];
    logic [31:0] slot [2][$];
    in_t         cur  [2];
    int          checks = 0;
    int          errors = 0;

    function automatic in_t mk(logic r, logic s, logic e, logic [2:0] op,
                               logic [25:0] imm, logic [31:0] rsv, logic [31:0] epc);
        in_t v;
        v.rst = r; v.stall = s; v.exc = e; v.op = op; v.imm = imm; v.rsv = rsv; v.epc = epc;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 1'b1, 1'b0, 3'd0, 26'd0, 32'd0, 32'd0);
    endfunction

    function automatic logic [31:0] ref_target(logic [2:0] op, logic [31:0] pc, logic [25:0] imm,
                                               logic [31:0] rsv, logic [31:0] epc);
        logic [31:0] seq;
        logic [15:0] off16;
        int          off;
        seq   = pc + 32'd4;
        off16 = imm[15:0];
        off   = int'($signed(off16)) * 4;
        case (op)
            3'd1:    return seq + 32'(off);
            3'd2:    return (seq & 32'hF000_0000) | (32'(imm) << 2);
            3'd3:    return rsv;
            3'd4:    return epc;
            default: return seq;
        endcase
    endfunction

    function automatic bit ref_align(int k, in_t v);
`ifdef NPC_ALIGN_CHECK_EN
        logic [31:0] t;
        if (slot[k].size() != 0) return 1'b0;
        if (!(v.op == 3'd3 || v.op == 3'd4)) return 1'b0;
        t = ref_target(v.op, m_pc[k], v.imm, v.rsv, v.epc);
        return (t % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_npc(int k, in_t v);
        if (v.rst) return RST_PC;
        if (v.exc || ref_align(k, v)) return EXC_PC;
        if (slot[k].size() != 0) return slot[k][0];
        if (k == 1 && v.op inside {3'd1, 3'd2, 3'd3}) return m_pc[k] + 32'd4;
        return ref_target(v.op, m_pc[k], v.imm, v.rsv, v.epc);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_comb(int k);
        in_t v;
        bit  pend;
        v    = cur[k];
        pend = (slot[k].size() != 0);
        chk($sformatf("npc%0d", k), o[k].npc, ref_npc(k, v));
        chk($sformatf("pc_plus4_%0d", k), o[k].pc_plus4, m_pc[k] + 32'd4);
        chk($sformatf("exc_epc%0d", k), o[k].exc_epc, pend ? m_pc[k] - 32'd4 : m_pc[k]);
        chk($sformatf("exc_bd%0d", k), 32'(o[k].exc_bd), 32'(pend));
        chk($sformatf("ds_err%0d", k), 32'(o[k].ds_err), 32'(pend && (v.op inside {3'd1, 3'd2, 3'd3, 3'd4})));
        chk($sformatf("align_err%0d", k), 32'(o[k].align_err), 32'(ref_align(k, v)));
    endtask

    task automatic apply(in_t a, in_t b);
        in0 = a; in1 = b;
        cur[0] = a; cur[1] = b;
        #1;
        check_comb(0);
        check_comb(1);
    endtask

    task automatic clock();
        for (int k = 0; k < 2; k++) begin
            in_t         v;
            logic [31:0] nx;
            bit          flush;
            v     = cur[k];
            nx    = ref_npc(k, v);
            flush = v.rst || v.exc || ref_align(k, v);
            if (flush) begin
                slot[k].delete();
                m_pc[k] = nx;
            end else if (!v.stall) begin
                if (slot[k].size() != 0) void'(slot[k].pop_front());
                else if (k == 1 && v.op inside {3'd1, 3'd2, 3'd3})
                    slot[k].push_back(ref_target(v.op, m_pc[k], v.imm, v.rsv, v.epc));
                m_pc[k] = nx;
            end
        end
        @(posedge clk);
        #1;
        chk("pc0", o[0].pc, m_pc[0]);
        chk("pc1", o[1].pc, m_pc[1]);
    endtask

    task automatic step(in_t a, in_t b);
        apply(a, b);
        clock();
    endtask

    row_t tbl [14];

    initial begin
        tbl[0]  = '{mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), 32'h0000_3004};
        tbl[1]  = '{mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), 32'h0000_3008};
        tbl[2]  = '{mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), 32'h0000_300C};
        tbl[3]  = '{mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), 32'h0000_3010};
        tbl[4]  = '{mk(0, 0, 0, 3'd1, 26'h000FFFC, 32'd0, 32'd0), 32'h0000_3004};
        tbl[5]  = '{mk(0, 0, 0, 3'd3, 26'd0, 32'h0000_3010, 32'd0), 32'h0000_3010};
        tbl[6]  = '{mk(0, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0), 32'h0000_3100};
        tbl[7]  = '{mk(0, 0, 0, 3'd4, 26'd0, 32'd0, 32'h0000_2000), 32'h0000_2000};
        tbl[8]  = '{mk(0, 0, 0, 3'd1, 26'h0000010, 32'd0, 32'd0), 32'h0000_2044};
        tbl[9]  = '{mk(0, 0, 0, 3'd7, 26'h3FFFFFF, 32'hFFFF_FFFF, 32'd0), 32'h0000_2048};
        tbl[10] = '{mk(0, 0, 0, 3'd3, 26'd0, 32'hFFFF_FFFC, 32'd0), 32'hFFFF_FFFC};
        tbl[11] = '{mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), 32'h0000_0000};
        tbl[12] = '{mk(0, 0, 0, 3'd2, 26'h3FFFFFF, 32'd0, 32'd0), 32'h0FFF_FFFC};
        tbl[13] = '{mk(0, 0, 0, 3'd1, 26'h0007FFF, 32'd0, 32'd0), 32'h1001_FFFC};

        // Bring both instances out of reset before the model is trusted.
        in0 = mk(1, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0);
        in1 = in0;
        @(posedge clk); @(posedge clk); #1;
        m_pc[0] = RST_PC; m_pc[1] = RST_PC;
        slot[0].delete(); slot[1].delete();
        step(mk(1, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0), mk(1, 1, 1, 3'd1, 26'd5, 32'd0, 32'd0));
        chk("reset_pc0", o[0].pc, 32'h0000_3000);
        chk("reset_pc1", o[1].pc, 32'h0000_3000);
        chk("reset_bd1", 32'(o[1].exc_bd), 32'd0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].v, idle());
            chk($sformatf("tbl%0d_npc", i), o[0].npc, tbl[i].exp_pc);
            clock();
            chk($sformatf("tbl%0d_pc", i), o[0].pc, tbl[i].exp_pc);
        end

        step(mk(1, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0), idle());
        chk("midrun_reset_pc0", o[0].pc, 32'h0000_3000);

        for (int i = 0; i < 4; i++) step(idle(), mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0));
        chk("ds_plus4_pc1", o[1].pc, 32'h0000_3010);
        step(idle(), mk(0, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0));
        chk("ds_slot_pc1", o[1].pc, 32'h0000_3014);
        chk("ds_slot_bd1", 32'(o[1].exc_bd), 32'd1);
        chk("ds_slot_epc1", o[1].exc_epc, 32'h0000_3010);
        apply(idle(), mk(0, 0, 0, 3'd3, 26'd0, 32'h0000_5000, 32'd0));
        chk("ds_err_jr1", 32'(o[1].ds_err), 32'd1);
        clock();
        chk("ds_redirect_pc1", o[1].pc, 32'h0000_3100);
        chk("ds_cleared_bd1", 32'(o[1].exc_bd), 32'd0);

        step(idle(), mk(0, 0, 0, 3'd3, 26'd0, 32'h0000_3010, 32'd0));
        step(idle(), mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0));
        chk("ds_jr_pc1", o[1].pc, 32'h0000_3010);
        step(idle(), mk(0, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0));
        apply(idle(), mk(0, 0, 1, 3'd0, 26'd0, 32'd0, 32'd0));
        chk("exc_epc_slot1", o[1].exc_epc, 32'h0000_3010);
        chk("exc_bd_slot1", 32'(o[1].exc_bd), 32'd1);
        clock();
        chk("exc_vector_pc1", o[1].pc, 32'h0000_4180);
        chk("exc_cleared_bd1", 32'(o[1].exc_bd), 32'd0);
        step(idle(), mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0));
        chk("exc_after_pc1", o[1].pc, 32'h0000_4184);

        step(mk(0, 0, 0, 3'd3, 26'd0, 32'h0000_3020, 32'd0), idle());
        for (int i = 0; i < 2; i++) begin
            step(mk(0, 1, 0, 3'd1, 26'h0000004, 32'd0, 32'd0), idle());
            chk("stall_hold_pc0", o[0].pc, 32'h0000_3020);
        end
        step(mk(0, 0, 0, 3'd1, 26'h0000004, 32'd0, 32'd0), idle());
        chk("stall_release_pc0", o[0].pc, 32'h0000_3034);
        step(mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0), idle());
        chk("stall_once_pc0", o[0].pc, 32'h0000_3038);

        step(idle(), mk(0, 0, 0, 3'd2, 26'h0000C40, 32'd0, 32'd0));
        for (int i = 0; i < 2; i++) begin
            step(idle(), mk(0, 1, 0, 3'd0, 26'd0, 32'd0, 32'd0));
            chk("ds_stall_pc1", o[1].pc, 32'h0000_4188);
            chk("ds_stall_bd1", 32'(o[1].exc_bd), 32'd1);
        end
        step(idle(), mk(0, 0, 0, 3'd0, 26'd0, 32'd0, 32'd0));
        chk("ds_stall_release_pc1", o[1].pc, 32'h0000_3100);

        apply(mk(0, 0, 0, 3'd3, 26'd0, 32'h0000_3002, 32'd0), idle());
`ifdef NPC_ALIGN_CHECK_EN
        chk("align_err0", 32'(o[0].align_err), 32'd1);
        chk("align_epc0", o[0].exc_epc, 32'h0000_3038);
        clock();
        chk("align_pc0", o[0].pc, 32'h0000_4180);
`else
        chk("align_err0", 32'(o[0].align_err), 32'd0);
        clock();
        chk("align_pc0", o[0].pc, 32'h0000_3002);
`endif

        for (int n = 0; n < 400; n++) begin
            in_t r [2];
            for (int k = 0; k < 2; k++) begin
                r[k].rst   = ($urandom_range(0, 39) == 0);
                r[k].exc   = ($urandom_range(0, 19) == 0);
                r[k].stall = ($urandom_range(0, 5) == 0);
                r[k].op    = 3'($urandom_range(0, 7));
                r[k].imm   = 26'($urandom);
                r[k].rsv   = $urandom;
                r[k].epc   = $urandom;
                if ($urandom_range(0, 3) != 0) r[k].rsv[1:0] = 2'b00;
                if ($urandom_range(0, 3) != 0) r[k].epc[1:0] = 2'b00;
            end
            step(r[0], r[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
